// File: rtl/ccip_rx_poller.sv
// ----------------------------------------------------------------------------
// ccip_rx_poller
//
// Receive path of the CPU-NIC interface. Polls per-flow RPC ring buffers in
// host memory with single-line CCI-P RDLINE_I reads on channel c0. It detects
// freshly written lines through a phase (ownership) bit and hands each RPC,
// tagged with its flow ID, to the NIC pipeline over a valid/ready handshake.
//
// Configuration macro: CCIP_RX_STATS_EN
//   defined   -> 32-bit wrapping poll / RPC counters on stat_polls, stat_rpcs
//   undefined -> no counters are built, stat_polls and stat_rpcs are tied to 0
//
// Ports:
//   clk              single clock for all logic
//   reset_n          synchronous, active-low reset
//   number_of_flows  index of the highest active flow (flows 0..number_of_flows)
//   rx_base_addr     cache-line address of flow 0, slot 0
//   start            enables issuing new polls
//   sRx_c0TxAlmFull  c0 request channel almost full
//   sTx_c0           registered c0 read request
//   sRx_c0           c0 response channel
//   rpc_out          received RPC (low $bits(RpcIf) bits of the line)
//   rpc_flow_id_out  flow ID of rpc_out
//   rpc_out_valid    rpc_out / rpc_flow_id_out valid
//   rpc_out_ready    consumer accepts the RPC
//   error            sticky flag: response tag did not match the outstanding read
//   stat_polls       reads issued
//   stat_rpcs        RPCs delivered
// ----------------------------------------------------------------------------

package ccip_rx_pkg;

    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    // RPC descriptor as laid out in the low bits of a ring line.
    typedef struct packed {
        logic [31:0] rpc_id;
        logic [15:0] fn_id;
        logic [15:0] arg;
    } RpcIf;

endpackage

module ccip_rx_poller
    import ccip_rx_pkg::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LRX_RING_SIZE     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  t_ccip_clAddr                 rx_base_addr,
    input  logic                         start,
    input  logic                         sRx_c0TxAlmFull,
    output t_if_ccip_c0_Tx               sTx_c0,
    input  t_if_ccip_c0_Rx               sRx_c0,
    output logic [$bits(RpcIf)-1:0]      rpc_out,
    output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
    output logic                         rpc_out_valid,
    input  logic                         rpc_out_ready,
    output logic                         error,
    output logic [31:0]                  stat_polls,
    output logic [31:0]                  stat_rpcs
);

    localparam int NUM_FLOWS = 1 << LMAX_NUM_OF_FLOWS;
    localparam int RPC_W     = $bits(RpcIf);
    localparam int TAG_W     = LMAX_NUM_OF_FLOWS + LRX_RING_SIZE;
    localparam logic [LRX_RING_SIZE-1:0] SLOT_LAST = '1;

    // NIC_ID only labels simulation traces of the original design.
    localparam int unused_nic_id = NIC_ID;

    typedef enum logic [1:0] {
        RxIdle,
        RxWait,
        RxOut
    } rx_state_t;

    rx_state_t                    state;
    rx_state_t                    state_next;
    logic [LMAX_NUM_OF_FLOWS-1:0] flow_cnt;
    logic [LMAX_NUM_OF_FLOWS-1:0] flow_cnt_next;
    logic [LMAX_NUM_OF_FLOWS-1:0] flow_adv;
    logic [LRX_RING_SIZE-1:0]     slot      [NUM_FLOWS];
    logic [LRX_RING_SIZE-1:0]     slot_next [NUM_FLOWS];
    logic [NUM_FLOWS-1:0]         phase;
    logic [NUM_FLOWS-1:0]         phase_next;

    logic [TAG_W-1:0]             cur_tag;
    t_ccip_mdata                  cur_mdata;
    t_ccip_clAddr                 cur_offset;
    t_ccip_clAddr                 cur_addr;

    t_if_ccip_c0_Tx               tx_next;
    logic [RPC_W-1:0]             rpc_next;
    logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_next;
    logic                         error_next;

    logic                         issue;
    logic                         handshake;
    logic                         rsp_rdline;
    logic                         rsp_tag_ok;
    logic                         rsp_owned;
    logic                         unused_rx;

    // Only the tag, type, valid and the RPC/phase bits of a response matter.
    assign unused_rx = ^sRx_c0;

    // The (flow, slot) pair doubles as the line offset from rx_base_addr and
    // as the mdata tag, since (f << LRX_RING_SIZE) + s == {f, s}.
    always_comb begin
        cur_tag                 = {flow_cnt, slot[flow_cnt]};
        cur_mdata               = '0;
        cur_mdata[TAG_W-1:0]    = cur_tag;
        cur_offset              = '0;
        cur_offset[TAG_W-1:0]   = cur_tag;
        cur_addr                = rx_base_addr + cur_offset;
    end

    // '>=' so that a runtime shrink of number_of_flows still wraps at once.
    always_comb begin
        if (flow_cnt >= number_of_flows) begin
            flow_adv = '0;
        end else begin
            flow_adv = flow_cnt + LMAX_NUM_OF_FLOWS'(1);
        end
    end

    always_comb begin
        rsp_rdline = sRx_c0.rspValid && (sRx_c0.hdr.resp_type == eRSP_RDLINE);
        rsp_tag_ok = (sRx_c0.hdr.mdata == cur_mdata);
        rsp_owned  = (sRx_c0.data[511] == phase[flow_cnt]);
    end

    assign rpc_out_valid = (state == RxOut);

    always_comb begin
        state_next    = state;
        flow_cnt_next = flow_cnt;
        slot_next     = slot;
        phase_next    = phase;
        tx_next       = '0;
        rpc_next      = rpc_out;
        rpc_flow_next = rpc_flow_id_out;
        error_next    = error;
        issue         = 1'b0;
        handshake     = 1'b0;

        case (state)
            RxIdle: begin
                if (start && !sRx_c0TxAlmFull) begin
                    issue                   = 1'b1;
                    tx_next.valid           = 1'b1;
                    tx_next.hdr.vc_sel      = eVC_VH0;
                    tx_next.hdr.cl_len      = eCL_LEN_1;
                    tx_next.hdr.req_type    = eREQ_RDLINE_I;
                    tx_next.hdr.address     = cur_addr;
                    tx_next.hdr.mdata       = cur_mdata;
                    state_next              = RxWait;
                end
            end

            RxWait: begin
                if (rsp_rdline) begin
                    if (!rsp_tag_ok) begin
                        // Stray line: flag it and keep waiting for ours.
                        error_next = 1'b1;
                    end else if (rsp_owned) begin
                        rpc_next      = sRx_c0.data[RPC_W-1:0];
                        rpc_flow_next = flow_cnt;
                        state_next    = RxOut;
                    end else begin
                        flow_cnt_next = flow_adv;
                        state_next    = RxIdle;
                    end
                end
            end

            RxOut: begin
                if (rpc_out_ready) begin
                    handshake               = 1'b1;
                    slot_next[flow_cnt]     = slot[flow_cnt] + LRX_RING_SIZE'(1);
                    // Host flips the phase bit every lap, so follow it.
                    if (slot[flow_cnt] == SLOT_LAST) begin
                        phase_next[flow_cnt] = ~phase[flow_cnt];
                    end
                    flow_cnt_next           = flow_adv;
                    state_next              = RxIdle;
                end
            end

            default: begin
                state_next = RxIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= RxIdle;
            flow_cnt        <= '0;
            for (int f = 0; f < NUM_FLOWS; f++) begin
                slot[f] <= '0;
            end
            phase           <= '1;
            sTx_c0          <= '0;
            rpc_out         <= '0;
            rpc_flow_id_out <= '0;
            error           <= 1'b0;
        end else begin
            state           <= state_next;
            flow_cnt        <= flow_cnt_next;
            for (int f = 0; f < NUM_FLOWS; f++) begin
                slot[f] <= slot_next[f];
            end
            phase           <= phase_next;
            sTx_c0          <= tx_next;
            rpc_out         <= rpc_next;
            rpc_flow_id_out <= rpc_flow_next;
            error           <= error_next;
        end
    end

`ifdef CCIP_RX_STATS_EN
    logic [31:0] poll_cnt;
    logic [31:0] rpc_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poll_cnt <= '0;
            rpc_cnt  <= '0;
        end else begin
            if (issue) begin
                poll_cnt <= poll_cnt + 32'd1;
            end
            if (handshake) begin
                rpc_cnt <= rpc_cnt + 32'd1;
            end
        end
    end

    assign stat_polls = poll_cnt;
    assign stat_rpcs  = rpc_cnt;
`else
    logic unused_stats;

    assign unused_stats = issue ^ handshake;
    assign stat_polls   = '0;
    assign stat_rpcs    = '0;
`endif

endmodule

// File: tb/tb_ccip_rx_poller.sv
// ----------------------------------------------------------------------------
// tb_ccip_rx_poller
//
// Self-checking bench for ccip_rx_poller (LMAX_NUM_OF_FLOWS=1, LRX_RING_SIZE=2).
// A host-memory model answers every read after a programmable delay; lines
// the host writes as "new" push an expected RPC into a scoreboard queue that
// is popped on every rpc_out handshake. Inputs change #1 after posedge; the
// monitor/responder samples and drives on negedge.
// ----------------------------------------------------------------------------

module tb_ccip_rx_poller;
    import ccip_rx_pkg::*;

    localparam int LF     = 1;
    localparam int LR     = 2;
    localparam int NLINES = 1 << (LF + LR);
    localparam int RPC_W  = $bits(RpcIf);
    localparam t_ccip_clAddr BASE = 42'h0_1234_5600;

    logic               clk;
    logic               reset_n;
    logic [LF-1:0]      number_of_flows;
    t_ccip_clAddr       rx_base_addr;
    logic               start;
    logic               sRx_c0TxAlmFull;
    t_if_ccip_c0_Tx     sTx_c0;
    t_if_ccip_c0_Rx     sRx_c0;
    logic [RPC_W-1:0]   rpc_out;
    logic [LF-1:0]      rpc_flow_id_out;
    logic               rpc_out_valid;
    logic               rpc_out_ready;
    logic               error;
    logic [31:0]        stat_polls;
    logic [31:0]        stat_rpcs;

    ccip_rx_poller #(
        .NIC_ID            (0),
        .LMAX_NUM_OF_FLOWS (LF),
        .LRX_RING_SIZE     (LR)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .number_of_flows (number_of_flows),
        .rx_base_addr    (rx_base_addr),
        .start           (start),
        .sRx_c0TxAlmFull (sRx_c0TxAlmFull),
        .sTx_c0          (sTx_c0),
        .sRx_c0          (sRx_c0),
        .rpc_out         (rpc_out),
        .rpc_flow_id_out (rpc_flow_id_out),
        .rpc_out_valid   (rpc_out_valid),
        .rpc_out_ready   (rpc_out_ready),
        .error           (error),
        .stat_polls      (stat_polls),
        .stat_rpcs       (stat_rpcs)
    );

    typedef struct {
        t_ccip_clAddr addr;
        t_ccip_mdata  mdata;
        int           cyc;
    } poll_t;

    typedef struct {
        logic [LF-1:0]    flow;
        logic [RPC_W-1:0] payload;
    } rpc_t;

    poll_t            poll_log[$];
    rpc_t             exp_q[$];
    logic             mem_phase   [NLINES];
    logic [RPC_W-1:0] mem_payload [NLINES];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int valid_seen = 0;
    int hs_cnt     = 0;
    int rsp_sent   = 0;
    int rsp_lat    = 2;

    bit           pend         = 0;
    int           pend_cnt     = 0;
    t_ccip_clAddr pend_addr;
    t_ccip_mdata  pend_mdata;
    bit           corrupt_next = 0;
    bit           umsg_next    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor, scoreboard and host-memory responder. A read logged at
    // negedge N0 is answered at negedge N(rsp_lat+1), so the response is
    // sampled rsp_lat+1 cycles after the request cycle.
    initial begin
        int   idx;
        rpc_t e;
        sRx_c0 = '0;
        forever begin
            @(negedge clk);
            if (rpc_out_valid === 1'b1) begin
                valid_seen++;
            end
            if (rpc_out_valid === 1'b1 && rpc_out_ready === 1'b1) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rpc_unexpected: got flow %0d data %h, required no delivery", rpc_flow_id_out, rpc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (rpc_out !== e.payload || rpc_flow_id_out !== e.flow) begin
                        errors++;
                        $display("[TB] FAIL rpc_data: got flow %0d data %h, required flow %0d data %h", rpc_flow_id_out, rpc_out, e.flow, e.payload);
                    end
                end
            end

            sRx_c0.rspValid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    idx                        = int'(pend_addr - BASE) & (NLINES - 1);
                    sRx_c0.hdr                 = '0;
                    sRx_c0.hdr.resp_type       = eRSP_RDLINE;
                    sRx_c0.hdr.mdata           = pend_mdata;
                    sRx_c0.data                = '0;
                    sRx_c0.data[RPC_W-1:0]     = mem_payload[idx];
                    sRx_c0.data[511]           = mem_phase[idx];
                    if (umsg_next) begin
                        sRx_c0.hdr.resp_type = eRSP_UMSG;
                        umsg_next            = 0;
                        pend_cnt             = 1;
                    end else if (corrupt_next) begin
                        sRx_c0.hdr.mdata = pend_mdata ^ 16'h0008;
                        corrupt_next     = 0;
                        pend_cnt         = 1;
                    end else begin
                        pend = 0;
                    end
                    sRx_c0.rspValid = 1'b1;
                    rsp_sent++;
                end else begin
                    pend_cnt--;
                end
            end

            if (sTx_c0.valid === 1'b1) begin
                poll_log.push_back('{addr: sTx_c0.hdr.address, mdata: sTx_c0.hdr.mdata, cyc: cyc});
                pend       = 1;
                pend_cnt   = rsp_lat;
                pend_addr  = sTx_c0.hdr.address;
                pend_mdata = sTx_c0.hdr.mdata;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        start           = 1'b0;
        sRx_c0TxAlmFull = 1'b0;
        rpc_out_ready   = 1'b0;
        number_of_flows = '0;
        rx_base_addr    = BASE;
        pend            = 0;
        corrupt_next    = 0;
        umsg_next       = 0;
        rsp_lat         = 2;
        for (int i = 0; i < NLINES; i++) begin
            mem_phase[i]   = 1'b0;
            mem_payload[i] = '0;
        end
        tick(3);
        reset_n = 1'b1;
        poll_log.delete();
        exp_q.delete();
        valid_seen = 0;
        hs_cnt     = 0;
    endtask

    task automatic wait_polls(input int n, input int budget, input string tag);
        int k = 0;
        while (poll_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (poll_log.size() < n) begin
            errors++;
            $display("[TB] FAIL %s: saw %0d polls, required %0d", tag, poll_log.size(), n);
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (rpc_out_valid !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (rpc_out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: rpc_out_valid=%b, required 1 within %0d cycles", tag, rpc_out_valid, budget);
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d RPCs undelivered, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sTx_c0.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tx_valid: got %b, required 0", sTx_c0.valid);
        end
        checks++;
        if (rpc_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rpc_valid: got %b, required 0", rpc_out_valid);
        end
        checks++;
        if (rpc_out !== '0 || rpc_flow_id_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rpc_out: got %h/%0d, required 0/0", rpc_out, rpc_flow_id_out);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_error: got %b, required 0", error);
        end
        checks++;
        if (stat_polls !== 32'd0 || stat_rpcs !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: got %0d/%0d, required 0/0", stat_polls, stat_rpcs);
        end
    endtask

    task automatic test_single_rpc();
        int exp_polls;
        int exp_rpcs;
        do_reset();
        mem_phase[0]   = 1'b1;
        mem_payload[0] = RPC_W'(16'hABCD);
        exp_q.push_back('{flow: '0, payload: RPC_W'(16'hABCD)});
        start = 1'b1;
        wait_polls(1, 20, "single_issue");
        start = 1'b0;
        checks++;
        if (poll_log[0].addr !== BASE || poll_log[0].mdata !== 16'd0) begin
            errors++;
            $display("[TB] FAIL single_req: got addr %h mdata %h, required %h / 0", poll_log[0].addr, poll_log[0].mdata, BASE);
        end
        wait_valid(20, "single_valid");
        repeat (3) begin
            tick(1);
            checks++;
            if (rpc_out_valid !== 1'b1 || rpc_out !== RPC_W'(16'hABCD) || rpc_flow_id_out !== '0) begin
                errors++;
                $display("[TB] FAIL single_hold: got valid %b data %h flow %0d, required 1 / abcd / 0", rpc_out_valid, rpc_out, rpc_flow_id_out);
            end
        end
        rpc_out_ready = 1'b1;
        wait_drain(20, "single_deliver");
        rpc_out_ready = 1'b0;
        tick(6);
        checks++;
        if (poll_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_one_read: got %0d reads, required 1", poll_log.size());
        end
        // slot[0] advanced: the next poll must target slot 1
        start = 1'b1;
        wait_polls(2, 20, "single_next_issue");
        start = 1'b0;
        checks++;
        if (poll_log[1].addr !== BASE + 42'd1 || poll_log[1].mdata !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_slot_adv: got addr %h mdata %h, required %h / 1", poll_log[1].addr, poll_log[1].mdata, BASE + 42'd1);
        end
        tick(8);
`ifdef CCIP_RX_STATS_EN
        exp_polls = poll_log.size();
        exp_rpcs  = hs_cnt;
`else
        exp_polls = 0;
        exp_rpcs  = 0;
`endif
        checks++;
        if (stat_polls !== 32'(exp_polls) || stat_rpcs !== 32'(exp_rpcs)) begin
            errors++;
            $display("[TB] FAIL single_stats: got %0d/%0d, required %0d/%0d", stat_polls, stat_rpcs, exp_polls, exp_rpcs);
        end
    endtask

    task automatic test_empty_rotation();
        t_ccip_clAddr ea;
        do_reset();
        number_of_flows = 1'b1;
        start = 1'b1;
        wait_polls(4, 60, "rot_issue");
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ea = BASE + t_ccip_clAddr'((i % 2) * (1 << LR));
            checks++;
            if (poll_log[i].addr !== ea || poll_log[i].mdata !== t_ccip_mdata'((i % 2) * (1 << LR))) begin
                errors++;
                $display("[TB] FAIL rot_addr%0d: got addr %h mdata %h, required %h", i, poll_log[i].addr, poll_log[i].mdata, ea);
            end
        end
        // response latency here is rsp_lat+1 cycles, period is latency + 2
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (poll_log[i].cyc - poll_log[i-1].cyc != rsp_lat + 3) begin
                errors++;
                $display("[TB] FAIL rot_period%0d: got %0d cycles, required %0d", i, poll_log[i].cyc - poll_log[i-1].cyc, rsp_lat + 3);
            end
        end
        tick(10);
        checks++;
        if (valid_seen != 0) begin
            errors++;
            $display("[TB] FAIL rot_no_rpc: rpc_out_valid seen %0d cycles, required 0", valid_seen);
        end
    endtask

    task automatic test_ring_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_phase[i]   = 1'b1;
            mem_payload[i] = RPC_W'(16'h0100 + i);
            exp_q.push_back('{flow: '0, payload: RPC_W'(16'h0100 + i)});
        end
        rpc_out_ready = 1'b1;
        start = 1'b1;
        wait_polls(6, 120, "wrap_issue");
        checks++;
        if (hs_cnt != 4 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL wrap_fifth_poll: got %0d deliveries, required 4", hs_cnt);
        end
        checks++;
        if (poll_log[4].addr !== BASE || poll_log[5].addr !== BASE || poll_log[4].mdata !== 16'd0) begin
            errors++;
            $display("[TB] FAIL wrap_slot0: got addr %h/%h, required %h", poll_log[4].addr, poll_log[5].addr, BASE);
        end
        mem_phase[0]   = 1'b0;
        mem_payload[0] = RPC_W'(16'h0200);
        exp_q.push_back('{flow: '0, payload: RPC_W'(16'h0200)});
        wait_drain(40, "wrap_resume");
        start = 1'b0;
        tick(10);
        checks++;
        if (hs_cnt != 5) begin
            errors++;
            $display("[TB] FAIL wrap_total: got %0d deliveries, required 5", hs_cnt);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        mem_phase[0]   = 1'b1;
        mem_payload[0] = RPC_W'(16'h5A5A);
        exp_q.push_back('{flow: '0, payload: RPC_W'(16'h5A5A)});
        start = 1'b1;
        wait_valid(30, "bp_valid");
        n = poll_log.size();
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if (rpc_out_valid !== 1'b1 || rpc_out !== RPC_W'(16'h5A5A)) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid %b data %h, required 1 / 5a5a", i, rpc_out_valid, rpc_out);
            end
        end
        checks++;
        if (poll_log.size() != n) begin
            errors++;
            $display("[TB] FAIL bp_no_issue: got %0d reads, required %0d", poll_log.size(), n);
        end
        rpc_out_ready = 1'b1;
        tick(1);
        checks++;
        if (rpc_out_valid !== 1'b0 || hs_cnt != 1) begin
            errors++;
            $display("[TB] FAIL bp_release: got valid %b handshakes %0d, required 0 / 1", rpc_out_valid, hs_cnt);
        end
        start = 1'b0;
        tick(10);
    endtask

    task automatic test_flow_control();
        int c0;
        do_reset();
        sRx_c0TxAlmFull = 1'b1;
        start = 1'b1;
        tick(8);
        checks++;
        if (poll_log.size() != 0) begin
            errors++;
            $display("[TB] FAIL almfull_block: got %0d reads, required 0", poll_log.size());
        end
        sRx_c0TxAlmFull = 1'b0;
        c0 = cyc;
        wait_polls(1, 10, "almfull_release");
        start = 1'b0;
        checks++;
        if (poll_log[0].cyc != c0 + 1) begin
            errors++;
            $display("[TB] FAIL almfull_timing: got issue cycle %0d, required %0d", poll_log[0].cyc, c0 + 1);
        end
        tick(10);
    endtask

    task automatic test_start_drop();
        do_reset();
        mem_phase[0]   = 1'b1;
        mem_payload[0] = RPC_W'(16'h7777);
        exp_q.push_back('{flow: '0, payload: RPC_W'(16'h7777)});
        rpc_out_ready = 1'b1;
        start = 1'b1;
        wait_polls(1, 20, "drop_issue");
        start = 1'b0;
        wait_drain(30, "drop_deliver");
        tick(10);
        checks++;
        if (poll_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL drop_no_more: got %0d reads, required 1", poll_log.size());
        end
    endtask

    task automatic test_bad_rsp();
        int r0;
        int k;
        do_reset();
        mem_phase[0]   = 1'b1;
        mem_payload[0] = RPC_W'(16'h1234);
        exp_q.push_back('{flow: '0, payload: RPC_W'(16'h1234)});
        rpc_out_ready = 1'b1;
        umsg_next     = 1;
        corrupt_next  = 1;
        r0 = rsp_sent;
        start = 1'b1;
        wait_polls(1, 20, "bad_issue");
        start = 1'b0;
        k = 0;
        while (rsp_sent < r0 + 1 && k < 30) begin
            tick(1);
            k++;
        end
        checks++;
        if (error !== 1'b0 || rpc_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL umsg_ignored: got error %b valid %b, required 0 / 0", error, rpc_out_valid);
        end
        k = 0;
        while (rsp_sent < r0 + 2 && k < 30) begin
            tick(1);
            k++;
        end
        checks++;
        if (error !== 1'b1 || rpc_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mdata_err: got error %b valid %b, required 1 / 0", error, rpc_out_valid);
        end
        wait_drain(30, "bad_then_good");
        tick(1);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %b, required 1", error);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem_phase[0]   = 1'b1;
        mem_payload[0] = RPC_W'(16'h9999);
        rsp_lat = 6;
        start = 1'b1;
        wait_polls(1, 20, "late_issue");
        start   = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(12);
        checks++;
        if (valid_seen != 0) begin
            errors++;
            $display("[TB] FAIL late_rsp_no_out: rpc_out_valid seen %0d cycles, required 0", valid_seen);
        end
        checks++;
        if (error !== 1'b0 || poll_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL late_rsp_quiet: got error %b reads %0d, required 0 / 1", error, poll_log.size());
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        start           = 1'b0;
        sRx_c0TxAlmFull = 1'b0;
        rpc_out_ready   = 1'b0;
        number_of_flows = '0;
        rx_base_addr    = BASE;
        test_reset();
        test_single_rpc();
        test_empty_rotation();
        test_ring_wrap();
        test_backpressure();
        test_flow_control();
        test_start_drop();
        test_bad_rsp();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
